uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, legal range 5..9: the number of data bits per frame.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: the width of BAUD_DIV.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, a power of two >= 2: the number of buffer entries when UART_TX_FIFO_EN is defined.
REQ-004 SHALL have port CLK  in  1  system clock; all logic is rising-edge.
REQ-005 SHALL have port RST  in  1  reset; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port P_DATA  in  DATA_WIDTH  data word to send.
REQ-007 SHALL have port DATA_VALID  in  1  P_DATA is valid.
REQ-008 SHALL have port DATA_READY  out  1  a buffer entry is free; a word is accepted on DATA_VALID && DATA_READY.
REQ-009 SHALL have port PAR_EN  in  1  parity bit enable.
REQ-010 SHALL have port PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-011 SHALL have port STOP2  in  1  0 = one stop bit, 1 = two stop bits.
REQ-012 SHALL have port BAUD_DIV  in  DIV_WIDTH  CLK cycles per bit; a value of 0 is treated as 1.
REQ-013 SHALL have port TX_OUT  out  1  serial line; idles high.
REQ-014 SHALL have port Busy  out  1  a frame is in progress.

Function
REQ-015 SHALL run an FSM with states IDLE, START, DATA, PARITY and STOP; transitions are IDLE->START, START->DATA, DATA->PARITY when PAR_EN is set, otherwise DATA->STOP, PARITY->STOP, and STOP->START or STOP->IDLE.
REQ-016 SHALL, in IDLE with the buffer non-empty, pop one word and latch the word, PAR_EN, PAR_TYP, STOP2 and BAUD_DIV; the START state begins on the next cycle.
REQ-017 SHALL hold each bit on TX_OUT for exactly max(BAUD_DIV,1) cycles, using the latched value; input changes mid-frame have no effect.
REQ-018 SHALL drive TX_OUT as: START=0; DATA = data bits LSB first, DATA_WIDTH bits; PARITY = XOR of the data bits, inverted when PAR_TYP=1; STOP=1 for 1 or 2 bit-times.
REQ-019 SHALL make each frame last exactly (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) x max(BAUD_DIV,1) cycles.
REQ-020 SHALL, at the end of the last stop bit with the buffer non-empty, pop the next word and enter START on the next cycle, with no idle bit between frames.
REQ-021 SHALL hold Busy=1 in START, DATA, PARITY and STOP, and Busy=0 in IDLE; TX_OUT=1 in IDLE.
REQ-022 SHALL drive DATA_READY = !full, combinationally from the buffer count; a push while full is ignored and P_DATA is not stored.
REQ-023 SHALL, on a simultaneous push and pop, leave the count unchanged and keep data ordering FIFO.
REQ-024 SHALL wrap the buffer pointers modulo FIFO_DEPTH with no overrun or underrun.

Reset
REQ-025 SHALL, with RST asserted, immediately force TX_OUT=1, Busy=0, FSM=IDLE, the buffer empty (DATA_READY=1) and the bit and baud counters to 0.
REQ-026 SHALL, on RST asserted mid-frame, abort the frame and flush all buffered words; after RST deasserts no partial frame resumes.

Configuration
REQ-027 SHALL, with UART_TX_FIFO_EN defined, use a FIFO_DEPTH-entry FIFO as the buffer.
REQ-028 SHALL, with UART_TX_FIFO_EN undefined, use a single holding register as the buffer (depth 1) and ignore FIFO_DEPTH; all other behaviour is identical.

Structure
REQ-029 SHALL take the FSM state encoding (enum, 3 bits) and the PAR_EVEN/PAR_ODD constants from the shared package uart_tx_pkg.
REQ-030 SHALL implement the buffer as sub-module uart_tx_fifo (synchronous FIFO with a depth parameter, where depth 1 is the holding register); the baud counter, bit counter, FSM and parity stay in uart_tx_param.

Verification
REQ-031 SHALL cover: DATA_WIDTH=8, BAUD_DIV=4, PAR_EN=1, PAR_TYP=0, STOP2=0, push 0xA5 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, each bit for 4 cycles; Busy high for 44 cycles.
REQ-032 SHALL cover: the same frame with PAR_TYP=1, STOP2=1 -> parity bit = 1, two stop bits, Busy high for 48 cycles.
REQ-033 SHALL cover: FIFO_DEPTH=4 with the macro defined, push 5 words back-to-back at BAUD_DIV=2 -> DATA_READY=0 only after the 5th push attempt while 4 entries are held; frames are contiguous with no idle cycle between them; order is preserved.
REQ-034 SHALL cover: BAUD_DIV=0, PAR_EN=0, push 0x3C -> each bit is 1 cycle and the frame is 10 cycles.
REQ-035 SHALL cover: change BAUD_DIV from 4 to 8 mid-frame -> the current frame stays at 4 cycles per bit and the next frame runs at 8 cycles per bit.
REQ-036 SHALL cover: assert RST in the 3rd data bit with 2 words queued -> TX_OUT=1, Busy=0 and DATA_READY=1 immediately, and no frame after RST deasserts.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the parameterised UART transmitter: FSM encoding,
// parity constants and the latched per-frame configuration.
package uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned MAX_DATA_WIDTH = 9;

  typedef struct packed {
    logic par_en;
    logic stop2;
  } frame_cfg_t;

  // Parity over a zero-extended data word; padding zeros do not change the XOR.
  function automatic logic frame_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic                      par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter; DEPTH=1 acts as
// a single holding register.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with optional parity and 1/2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  output logic                  TX_OUT,
  output logic                  Busy
);

`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int unsigned BUF_DEPTH = FIFO_EN ? FIFO_DEPTH : 1;
  localparam int unsigned BIT_CW    = 4;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  frame_cfg_t            cfg_q, cfg_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic                  buf_empty;
  logic                  pop_c;
  logic                  bit_end_c;
  logic                  last_stop_c;

  uart_tx_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst       (RST),
    .push      (DATA_VALID),
    .push_data (P_DATA),
    .pop       (pop_c),
    .pop_data  (buf_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign DATA_READY  = !buf_full;
  assign TX_OUT      = tx_q;
  assign Busy        = busy_q;
  assign bit_end_c   = (baud_cnt_q == div_q - DIV_WIDTH'(1));
  assign last_stop_c = cfg_q.stop2 ? (bit_cnt_q == BIT_CW'(1)) : 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      div_q      <= DIV_WIDTH'(1);
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cfg_q      <= '0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    par_bit_d  = par_bit_q;
    pop_c      = 1'b0;
    tx_d       = 1'b1;
    busy_d     = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      ST_START: begin
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = cfg_q.par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (last_stop_c) state_d = ST_IDLE;
          else             bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame starts from idle or straight out of the final stop bit.
    if (!buf_empty && ((state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && bit_end_c && last_stop_c))) begin
      pop_c      = 1'b1;
      state_d    = ST_START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = buf_data;
      div_d      = (BAUD_DIV == '0) ? DIV_WIDTH'(1) : BAUD_DIV;
      cfg_d      = '{par_en: PAR_EN, stop2: STOP2};
      par_bit_d  = frame_parity(MAX_DATA_WIDTH'(buf_data), PAR_TYP);
    end

    // Line outputs are registered, so they follow the next state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: a frame-level line model compared every
// cycle, plus literal frame expectations. Honours UART_TX_FIFO_EN.
module tb_uart_tx_param;

  localparam int unsigned DW   = 8;
  localparam int unsigned DIVW = 16;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   p_data;
  logic            data_valid;
  logic            data_ready;
  logic            par_en;
  logic            par_typ;
  logic            stop2;
  logic [DIVW-1:0] baud_div;
  logic            tx_out;
  logic            busy;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_param #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (DIVW),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .DATA_READY (data_ready),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
    .BAUD_DIV   (baud_div),
    .TX_OUT     (tx_out),
    .Busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending words plus the line level for each remaining cycle of the frame.
  logic [DW-1:0] m_buf[$];
  logic          m_rest[$];
  logic          m_tx   = 1'b1;
  logic          m_busy = 1'b0;

  task automatic model_load(input logic [DW-1:0] w);
    logic bits[$];
    int   d;
    d = (baud_div == 0) ? 1 : int'(baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(w[i]);
    if (par_en) bits.push_back((^w) ^ par_typ);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < d; k++) m_rest.push_back(bits[i]);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_buf.delete();
        m_rest.delete();
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end else begin
        logic was_ready;
        was_ready = (m_buf.size() < DEPTH);
        if (m_rest.size() == 0 && m_buf.size() != 0) begin
          model_load(m_buf.pop_front());
          m_tx   = m_rest.pop_front();
          m_busy = 1'b1;
        end else if (m_rest.size() != 0) begin
          m_tx = m_rest.pop_front();
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
        end
        if (data_valid && was_ready) m_buf.push_back(p_data);
      end
    end
  end

  // Per-cycle compare and capture of busy cycles.
  logic cap[$];
  int   busy_cycles = 0;
  int   busy_falls  = 0;
  logic prev_busy   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("tx_out", tx_out, m_tx);
      check("busy", busy, m_busy);
      check("data_ready", data_ready, m_buf.size() < DEPTH);
      if (busy === 1'b1) begin
        cap.push_back(tx_out);
        busy_cycles++;
      end
      if (prev_busy && busy !== 1'b1) busy_falls++;
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic clear_cap();
    cap.delete();
    busy_cycles = 0;
    busy_falls  = 0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    p_data     = w;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done;
    done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (!busy && !m_busy && m_rest.size() == 0 && m_buf.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: no return to idle within %0d cycles", name, limit);
    end
  endtask

  // Compare captured line against a literal frame (bit 0 sent first).
  task automatic check_frame(input string name, input logic [15:0] v, input int nbits,
                             input int div, input int base);
    for (int i = 0; i < nbits; i++)
      for (int j = 0; j < div; j++)
        if (base + i * div + j < cap.size())
          check(name, cap[base + i * div + j], v[i]);
  endtask

  logic [4:0] ready_exp;

  initial begin
    rst = 1'b1; p_data = '0; data_valid = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; baud_div = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", tx_out, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", data_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0xA5, even parity, one stop bit, 4 cycles per bit.
    clear_cap();
    baud_div = 16'd4; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    push_word(8'hA5);
    wait_idle("frame_a5_even", 200);
    check_int("a5_even_busy_cycles", busy_cycles, 44);
    check_frame("a5_even_bits", 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 4, 0);

    // Odd parity with two stop bits.
    clear_cap();
    par_typ = 1'b1; stop2 = 1'b1;
    push_word(8'hA5);
    wait_idle("frame_a5_odd", 200);
    check_int("a5_odd_busy_cycles", busy_cycles, 48);
    check_frame("a5_odd_bits", 16'({1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}), 12, 4, 0);

    // Divisor 0 behaves as 1.
    clear_cap();
    baud_div = 16'd0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    push_word(8'h3C);
    wait_idle("frame_3c_div0", 100);
    check_int("div0_busy_cycles", busy_cycles, 10);
    check_frame("div0_bits", 16'({1'b1, 8'h3C, 1'b0}), 10, 1, 0);

    // Five back-to-back push attempts at 2 cycles per bit.
`ifdef UART_TX_FIFO_EN
    ready_exp = 5'b01111;
`else
    ready_exp = 5'b00010;
`endif
    clear_cap();
    baud_div = 16'd2;
    for (int i = 0; i < 5; i++) begin
      push_word(8'h11 * 8'(i + 1));
      check("burst_ready", data_ready, ready_exp[i]);
    end
    wait_idle("burst", 400);
    check_int("burst_busy_cycles", busy_cycles, (DEPTH == 4) ? 100 : 40);
    check_int("burst_contiguous", busy_falls, 1);
    check_frame("burst_first", 16'({1'b1, 8'h11, 1'b0}), 10, 2, 0);

    // Divisor change mid-frame only affects the following frame.
    clear_cap();
    baud_div = 16'd4;
    push_word(8'h55);
    @(posedge clk); #1;
    push_word(8'h0F);
    repeat (8) @(posedge clk);
    #1;
    baud_div = 16'd8;
    wait_idle("baud_change", 400);
    check_int("baud_change_cycles", busy_cycles, 120);
    check_int("baud_change_contiguous", busy_falls, 1);
    check_frame("baud_first", 16'({1'b1, 8'h55, 1'b0}), 10, 4, 0);
    check_frame("baud_second", 16'({1'b1, 8'h0F, 1'b0}), 10, 8, 40);

    // Reset during the third data bit with words queued.
    baud_div = 16'd4; par_en = 1'b1;
    push_word(8'hA5);
    @(posedge clk); #1;
    push_word(8'h12);
    push_word(8'h34);
    repeat (11) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_tx", tx_out, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", data_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_cap();
    repeat (100) @(posedge clk);
    #1;
    check_int("post_reset_busy_cycles", busy_cycles, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
